// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a registered-read FIFO and serialises each one
// as a UART frame: start bit, DATA_WIDTH data bits LSB first, optional parity,
// then 1 or 2 stop bits. Frames run back to back while the FIFO has data and
// tx_en is high. The line idles high.
module fifo_uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_WIDTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state,      state_next;
    logic [BAUD_W-1:0]     baud_cnt,   baud_next;
    logic [BIT_W-1:0]      bit_cnt,    bit_next;
    logic [DATA_WIDTH-1:0] shift_reg,  shift_next;
    logic                  parity_bit, parity_next;
    logic                  tx_next;
    logic                  baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign busy      = (state != S_IDLE);

    // Next-state, counter, pop and tx-line decisions for the frame sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement can infer a latch.
        state_next  = state;
        baud_next   = baud_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        parity_next = parity_bit;
        fifo_rd_en  = 1'b0;
        tx_done     = 1'b0;

        case (state)
            S_IDLE: begin
                baud_next  = '0;
                bit_next   = '0;
                fifo_rd_en = tx_en & ~fifo_empty;
                if (tx_en & ~fifo_empty) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // Read data is valid now, one cycle after the pop.
                baud_next   = '0;
                bit_next    = '0;
                shift_next  = fifo_rd_data;
                parity_next = (^fifo_rd_data) ^ (PARITY == 1);
                state_next  = S_START;
            end
            S_START: begin
                baud_next = baud_wrap ? '0 : baud_cnt + 1'b1;
                if (baud_wrap) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                baud_next = baud_wrap ? '0 : baud_cnt + 1'b1;
                if (baud_wrap) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                baud_next = baud_wrap ? '0 : baud_cnt + 1'b1;
                if (baud_wrap) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                baud_next = baud_wrap ? '0 : baud_cnt + 1'b1;
                if (baud_wrap) begin
                    if (bit_cnt == STOP_LAST) begin
                        tx_done    = 1'b1;
                        bit_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // The line level registered for the next cycle follows the state
        // and bit that will be current then.
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = parity_next;
            default:  tx_next = 1'b1;
        endcase
    end

    // State, counters, shift register and the registered tx line.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values; all of it, including the shift
        // register, is reset so the line is high and idle straight away.
        if (!rst_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx         <= tx_next;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three instances (8N1, 8E2, 8O1) at 4 clocks per bit, each
// fed by a queue-based FIFO model with registered read data and a registered
// empty flag. Expected frames come from a bit-list model of the UART format.
module tb_fifo_uart_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 250_000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int NDUT      = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [NDUT-1:0] tx_en = '0;
    logic [NDUT-1:0] fifo_empty = '1;
    logic [NDUT-1:0] fifo_rd_en;
    logic [NDUT-1:0] tx;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] tx_done;
    logic [7:0]      rd_data [NDUT] = '{default: 8'h00};
    logic [7:0]      fq [NDUT][$];

    int cyc = 0;
    int rd_pulses [NDUT] = '{default: 0};
    int rd_cyc    [NDUT] = '{default: 0};
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(8),
                   .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]),
        .fifo_rd_data(rd_data[0]), .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]),
        .busy(busy[0]), .tx_done(tx_done[0]));

    fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(8),
                   .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]),
        .fifo_rd_data(rd_data[1]), .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]),
        .busy(busy[1]), .tx_done(tx_done[1]));

    fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(8),
                   .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en[2]), .fifo_empty(fifo_empty[2]),
        .fifo_rd_data(rd_data[2]), .fifo_rd_en(fifo_rd_en[2]), .tx(tx[2]),
        .busy(busy[2]), .tx_done(tx_done[2]));

    // FIFO models: pop on rd_en, data valid next cycle, empty flag registered.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NDUT; k++) begin
            if (fifo_rd_en[k]) begin
                rd_pulses[k] <= rd_pulses[k] + 1;
                rd_cyc[k]    <= cyc;
                if (fq[k].size() != 0) begin
                    rd_data[k] <= fq[k].pop_front();
                end
            end
            fifo_empty[k] <= (fq[k].size() == 0);
        end
    end

    function automatic int par_of(input int k);
        case (k)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stops_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    // Frame as a list of line levels, first bit in bits[0]; returns bit count.
    function automatic int frame_ref(input logic [7:0] b, input int par,
                                     input int stops, output logic [15:0] bits);
        int n;
        int ones;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        n    = 9;
        ones = $countones(b);
        if (par == 2) begin
            bits[n] = (ones % 2 == 1);   // make total count of ones even
            n++;
        end else if (par == 1) begin
            bits[n] = (ones % 2 == 0);   // make total count of ones odd
            n++;
        end
        return n + stops;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int k, input string tag,
                              output int start_c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx[k] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " start seen"}, 64'(ok), 64'd1);
        start_c = cyc;
    endtask

    // Capture one whole frame cycle by cycle and compare with the model.
    // hook_kind 1 drops tx_en, 2 pushes hook_byte, at frame cycle hook_at.
    task automatic run_frame(input int k, input logic [7:0] b, input string tag,
                             input int hook_at, input int hook_kind,
                             input logic [7:0] hook_byte,
                             output int start_c, output int end_c);
        logic [15:0] bits;
        logic [63:0] tv, dv, bv, ev;
        logic [7:0]  dec;
        int          nbits, len;
        bit          ok;
        tv = '0; dv = '0; bv = '0; ev = '0; end_c = 0;
        nbits = frame_ref(b, par_of(k), stops_of(k), bits);
        len   = nbits * CPB;
        wait_start(k, tag, start_c, ok);
        if (!ok) return;
        check({tag, " pop-to-start"}, 64'(start_c - rd_cyc[k]), 64'd2);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            tv[i] = tx[k];
            dv[i] = tx_done[k];
            bv[i] = busy[k];
            if (i == hook_at) begin
                if (hook_kind == 1) tx_en[k] = 1'b0;
                else if (hook_kind == 2) fq[k].push_back(hook_byte);
            end
        end
        end_c = cyc;
        for (int i = 0; i < len; i++) ev[i] = bits[i / CPB];
        check({tag, " tx"}, tv, ev);
        check({tag, " tx_done"}, dv, 64'd1 << (len - 1));
        check({tag, " busy"}, bv, (64'd1 << len) - 64'd1);
        for (int i = 0; i < 8; i++) dec[i] = tv[(1 + i) * CPB + CPB / 2];
        check({tag, " byte"}, 64'(dec), 64'(b));
        if (par_of(k) != 0)
            check({tag, " parity"}, 64'(tv[9 * CPB + CPB / 2]), 64'(bits[9]));
        @(negedge clk);
        check({tag, " idle after"}, {62'd0, busy[k], tx[k]}, 64'd1);
    endtask

    // Watch a quiet window: no pop, line high, not busy.
    task automatic idle_window(input int k, input int ncyc, input string tag);
        bit saw_rd, saw_low, saw_busy;
        int p0;
        saw_rd = 1'b0; saw_low = 1'b0; saw_busy = 1'b0;
        p0 = rd_pulses[k];
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (fifo_rd_en[k] !== 1'b0) saw_rd = 1'b1;
            if (tx[k] !== 1'b1) saw_low = 1'b1;
            if (busy[k] !== 1'b0) saw_busy = 1'b1;
        end
        check({tag, " rd_en seen"}, 64'(saw_rd), 64'd0);
        check({tag, " tx low seen"}, 64'(saw_low), 64'd0);
        check({tag, " busy seen"}, 64'(saw_busy), 64'd0);
        check({tag, " pops"}, 64'(rd_pulses[k] - p0), 64'd0);
    endtask

    initial begin
        int  s0, e0, s1, e1, s2, e2, p;
        bit  ok;

        // Reset state of every instance.
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("reset dut%0d", k),
                  {60'd0, tx[k], busy[k], tx_done[k], fifo_rd_en[k]}, 64'b1000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 8N1 frame of 0xA5.
        p = rd_pulses[0];
        fq[0].push_back(8'hA5);
        @(negedge clk);
        tx_en[0] = 1'b1;
        run_frame(0, 8'hA5, "t1 a5", -1, 0, 8'h00, s0, e0);
        check("t1 pops", 64'(rd_pulses[0] - p), 64'd1);
        check("t1 fifo level", 64'(fq[0].size()), 64'd0);

        // Back-to-back frames with the minimum gap.
        p = rd_pulses[0];
        fq[0].push_back(8'h00);
        fq[0].push_back(8'hFF);
        fq[0].push_back(8'h3C);
        run_frame(0, 8'h00, "t2 00", -1, 0, 8'h00, s0, e0);
        run_frame(0, 8'hFF, "t2 ff", -1, 0, 8'h00, s1, e1);
        check("t2 gap1", 64'(s1 - e0 - 1), 64'd2);
        run_frame(0, 8'h3C, "t2 3c", -1, 0, 8'h00, s2, e2);
        check("t2 gap2", 64'(s2 - e1 - 1), 64'd2);
        check("t2 pops", 64'(rd_pulses[0] - p), 64'd3);

        // Even parity, two stop bits; then odd parity on the same byte.
        fq[1].push_back(8'h07);
        @(negedge clk);
        tx_en[1] = 1'b1;
        run_frame(1, 8'h07, "t3 8e2", -1, 0, 8'h00, s0, e0);
        check("t3 8e2 length", 64'(e0 - s0 + 1), 64'd48);
        tx_en[1] = 1'b0;
        fq[2].push_back(8'h07);
        @(negedge clk);
        tx_en[2] = 1'b1;
        run_frame(2, 8'h07, "t3 8o1", -1, 0, 8'h00, s0, e0);
        check("t3 8o1 length", 64'(e0 - s0 + 1), 64'd44);
        tx_en[2] = 1'b0;

        // Empty FIFO with tx_en high, then tx_en dropped mid-frame.
        idle_window(0, 100, "t4 empty");
        p = rd_pulses[0];
        fq[0].push_back(8'h55);
        fq[0].push_back(8'h12);
        run_frame(0, 8'h55, "t4 55", 10, 1, 8'h00, s0, e0);
        idle_window(0, 30, "t4 after drop");
        check("t4 pops", 64'(rd_pulses[0] - p), 64'd1);
        check("t4 fifo level", 64'(fq[0].size()), 64'd1);

        // FIFO write during a frame; new word popped in the first IDLE cycle.
        tx_en[0] = 1'b1;
        run_frame(0, 8'h12, "t6 12", 8, 2, 8'h9B, s0, e0);
        run_frame(0, 8'h9B, "t6 9b", -1, 0, 8'h00, s1, e1);
        check("t6 pop cycle", 64'(rd_cyc[0]), 64'(e0 + 1));
        check("t6 gap", 64'(s1 - e0 - 1), 64'd2);

        // Reset in data bit 3 of 0x81.
        p = rd_pulses[0];
        fq[0].push_back(8'h81);
        wait_start(0, "t5 81", s0, ok);
        repeat (17) @(negedge clk);
        check("t5 bit3 level", 64'(tx[0]), 64'd0);
        rst_n = 1'b0;
        #1;
        check("t5 reset outputs",
              {60'd0, tx[0], busy[0], tx_done[0], fifo_rd_en[0]}, 64'b1000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_window(0, 50, "t5 post reset");
        check("t5 pops", 64'(rd_pulses[0] - p), 64'd1);
        check("t5 fifo level", 64'(fq[0].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain stage that sits directly downstream of the block-RAM byte FIFO. It pops one word at a time through the FIFO's registered-read interface and serialises it onto a UART TX line: start bit, DATA_WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits. It runs back-to-back while the FIFO is non-empty and `tx_en` is high, and idles with the line high otherwise.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT`: localparam, CLK_FREQ / BAUD_RATE with integer truncation (434 at defaults); must be >= 2.
- `DATA_WIDTH`, default 8: bits per frame, legal range 5..9; matches the FIFO word width.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `tx_en` input 1: permission to start new frames.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rd_data` input DATA_WIDTH: FIFO registered read data, valid the cycle after an accepted `fifo_rd_en`.
- `fifo_rd_en` output 1: pop request to the FIFO. Combinational.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high in every state except IDLE.
- `tx_done` output 1: one-cycle pulse at the end of each frame.

## Operation
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE: `fifo_rd_en` = `tx_en` & !`fifo_empty`. If it is 1, go to FETCH; otherwise stay in IDLE.
- FETCH: this is the FIFO read-latency cycle. On exiting FETCH:
  - latch `fifo_rd_data` into the shift register;
  - compute the parity bit as the XOR of the data bits, inverted when PARITY = 1;
  - go to START.
- START: drive `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive `tx` = shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - A bit counter runs 0..DATA_WIDTH-1.
  - After the last bit, go to PARITY if PARITY != 0, else go to STOP.
- PARITY: drive the parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: drive `tx` = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On the final cycle, pulse `tx_done` and go to IDLE.
- Baud counter:
  - width is $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary;
  - is held at 0 in IDLE and FETCH.
- `tx` is a registered output driven from the state and the current bit.
- `tx_en` is sampled only in IDLE. Deasserting it mid-frame does not abort; the current frame completes.
- `fifo_empty` is ignored outside IDLE. `fifo_rd_en` is 0 outside IDLE, so exactly one pop happens per frame.
- FIFO writes during a frame have no effect on the frame in progress.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `tx_done` = 0, `fifo_rd_en` = 0, state = IDLE, counters = 0, shift register = 0.
- Reset asserted mid-frame: `tx` returns high asynchronously and the frame is abandoned. The popped word is lost; no re-read is attempted.
- If cycle T is in IDLE with `fifo_rd_en` = 1:
  - cycle T+1 is FETCH;
  - `tx` falls at the edge ending cycle T+1, so it is low from cycle T+2.
- Frame length is (1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles, measured from the first low cycle of `tx`.
- `tx_done` is high during the last stop-bit cycle.
- Inter-frame gap with a non-empty FIFO is 2 extra high cycles (IDLE + FETCH). The next start bit is low 2 cycles after the previous stop bit ends.
- `busy` rises in cycle T+1 (FETCH) and falls in the cycle after the `tx_done` pulse.
- Baud period is exact to the integer CLKS_PER_BIT. Truncation error is not compensated.

## Test plan
1. CLK_FREQ=1_000_000, BAUD_RATE=250_000 (CLKS_PER_BIT=4), 8N1. Preload the FIFO with 0xA5 and raise `tx_en`.
   - Expect exactly one `fifo_rd_en` pulse.
   - `tx` sequence per 4 cycles: 0,1,0,1,0,0,1,0,1,1.
   - `tx_done` pulses once, 40 cycles after the start bit begins; the FIFO is empty afterwards.
2. Preload 0x00, 0xFF, 0x3C with `tx_en` held high.
   - Expect three frames, each separated by exactly 2 extra high cycles.
   - Expect three `fifo_rd_en` pulses and decoded bytes matching in order.
3. PARITY=2, STOP_BITS=2, send 0x07.
   - Parity bit = 1, then 8 stop cycles high.
   - Frame = 48 cycles.
   - With PARITY=1 the parity bit for the same byte = 0.
4. Empty FIFO, `tx_en`=1 for 100 cycles.
   - `fifo_rd_en` never asserts, `tx` stays 1, `busy` stays 0.
   - Then drop `tx_en` mid-frame of 0x55: the frame completes and no further pop occurs.
5. Assert `rst_n`=0 during the DATA bit 3 of 0x81.
   - `tx`=1 immediately, `busy`=0, `tx_done`=0.
   - After release with the FIFO empty, the line stays idle.
6. Write to the FIFO during an ongoing frame.
   - The active frame bits are unchanged.
   - The new word is popped in the first IDLE cycle after `tx_done`.
